// File: rtl/set_counter_multi_if.sv
// Host handshake and job bus for set_counter_multi: job fields and start strobe in, status and count out.
interface set_counter_multi_if #(
  parameter int unsigned COORD_W = 4,
  parameter int unsigned N_CIRC  = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned K_W     = 2
);
  logic                          en;
  logic [N_CIRC*2*COORD_W-1:0]   central;
  logic [N_CIRC*COORD_W-1:0]     radius;
  logic [N_CIRC-1:0]             mask;
  logic [1:0]                    mode;
  logic [K_W-1:0]                k;
  logic                          busy;
  logic                          valid;
  logic [CNT_W-1:0]              candidate;

  modport master (
    output en, central, radius, mask, mode, k,
    input  busy, valid, candidate
  );

  modport slave (
    input  en, central, radius, mask, mode, k,
    output busy, valid, candidate
  );
endinterface

// File: rtl/set_counter_multi.sv
// Counts grid points satisfying a set expression (ALL/ANY/EXACT k/AT-LEAST k) over masked circles.
// Raster scan issues one point per clock into a 3-stage distance/hit/accumulate pipeline.
module set_counter_multi #(
  parameter int unsigned GRID    = 8,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned N_CIRC  = 3,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned K_W     = 2
) (
  input logic               clk,
  input logic               rst,
  set_counter_multi_if.slave bus
);

  localparam int unsigned H_W   = $clog2(N_CIRC + 1);
  localparam int unsigned S_W   = 2 * COORD_W + 1;
  localparam int unsigned CMP_W = (H_W > K_W) ? H_W : K_W;
  localparam logic [COORD_W-1:0] GridC = COORD_W'(GRID);
  localparam logic [COORD_W-1:0] OneC  = COORD_W'(1);

  localparam logic [1:0] ModeAll     = 2'd0;
  localparam logic [1:0] ModeAny     = 2'd1;
  localparam logic [1:0] ModeExact   = 2'd2;
  localparam logic [1:0] ModeAtLeast = 2'd3;

  typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

  state_e                      state_q, state_d;
  logic [1:0]                  drain_q, drain_d;
  logic [COORD_W-1:0]          px_q, px_d, py_q, py_d;
  logic                        busy_q, busy_d;
  logic                        valid_q, valid_d;
  logic                        start, issue;

  // Job fields latched at the accepting edge; bus inputs are don't-care afterwards.
  logic [N_CIRC*2*COORD_W-1:0] central_q;
  logic [N_CIRC*COORD_W-1:0]   radius_q;
  logic [N_CIRC-1:0]           mask_q;
  logic [1:0]                  mode_q;
  logic [K_W-1:0]              k_q;

  logic                        v0_q, v1_q, v2_q;
  logic [COORD_W-1:0]          p0x_q, p0y_q;
  logic [N_CIRC-1:0][COORD_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic [N_CIRC-1:0]           hit_q, hit_d;
  logic [N_CIRC-1:0]           act;
  logic [CNT_W-1:0]            cand_q;

  logic [H_W-1:0]              h, act_cnt;
  logic [CMP_W-1:0]            h_c, k_c, act_c;
  logic                        pred;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      drain_q <= 2'd0;
      px_q    <= OneC;
      py_q    <= OneC;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      px_q    <= px_d;
      py_q    <= py_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    px_d    = px_q;
    py_d    = py_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    start   = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.en) begin
          start   = 1'b1;
          busy_d  = 1'b1;
          px_d    = OneC;
          py_d    = OneC;
          state_d = StScan;
        end
      end
      StScan: begin
        issue = 1'b1;
        if (px_q == GridC) begin
          px_d = OneC;
          if (py_q == GridC) begin
            py_d    = OneC;
            drain_d = 2'd0;
            state_d = StDrain;
          end else begin
            py_d = py_q + OneC;
          end
        end else begin
          px_d = px_q + OneC;
        end
      end
      StDrain: begin
        drain_d = drain_q + 2'd1;
        // Third drain edge coincides with the last point's accumulate.
        if (drain_q == 2'd2) begin
          drain_d = 2'd0;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Job latch
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      central_q <= '0;
      radius_q  <= '0;
      mask_q    <= '0;
      mode_q    <= ModeAll;
      k_q       <= '0;
    end else if (start) begin
      central_q <= bus.central;
      radius_q  <= bus.radius;
      mask_q    <= bus.mask;
      mode_q    <= bus.mode;
      k_q       <= bus.k;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-circle distance and hit logic
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N_CIRC; g++) begin : g_circ
    logic [COORD_W-1:0] cx, cy, rr;
    logic [S_W-1:0]     dist_sq, rad_sq;

    // Circle 0 sits in the MSBs of the packed fields.
    assign cx     = central_q[(N_CIRC-g)*2*COORD_W-1 -: COORD_W];
    assign cy     = central_q[(N_CIRC-g)*2*COORD_W-COORD_W-1 -: COORD_W];
    assign rr     = radius_q[(N_CIRC-g)*COORD_W-1 -: COORD_W];
    assign act[g] = mask_q[N_CIRC-1-g];

    assign dx_d[g] = (p0x_q >= cx) ? (p0x_q - cx) : (cx - p0x_q);
    assign dy_d[g] = (p0y_q >= cy) ? (p0y_q - cy) : (cy - p0y_q);

    assign dist_sq  = S_W'(dx_q[g]) * S_W'(dx_q[g]) + S_W'(dy_q[g]) * S_W'(dy_q[g]);
    assign rad_sq   = S_W'(rr) * S_W'(rr);
    assign hit_d[g] = act[g] & (dist_sq <= rad_sq);
  end

  // ---------------------------------------------------------------------------
  // Mode predicate on the registered hit vector
  // ---------------------------------------------------------------------------
  always_comb begin
    h       = '0;
    act_cnt = '0;
    for (int i = 0; i < N_CIRC; i++) begin
      h       = h + H_W'(hit_q[i]);
      act_cnt = act_cnt + H_W'(act[i]);
    end
  end

  always_comb begin
    h_c   = CMP_W'(h);
    k_c   = CMP_W'(k_q);
    act_c = CMP_W'(act_cnt);
    pred  = 1'b0;
    unique case (mode_q)
      ModeAll:     pred = (mask_q != '0) && (h_c == act_c);
      ModeAny:     pred = (h_c != '0);
      ModeExact:   pred = (h_c == k_c);
      ModeAtLeast: pred = (h_c >= k_c);
      default:     pred = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline: issue -> S1 (|dx|,|dy|) -> S2 (hit) -> S3 (accumulate)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      p0x_q  <= OneC;
      p0y_q  <= OneC;
      dx_q   <= '0;
      dy_q   <= '0;
      hit_q  <= '0;
      cand_q <= '0;
    end else begin
      v0_q <= issue;
      if (issue) begin
        p0x_q <= px_q;
        p0y_q <= py_q;
      end
      v1_q  <= v0_q;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      v2_q  <= v1_q;
      hit_q <= hit_d;
      if (start) begin
        cand_q <= '0;
      end else if (v2_q && pred) begin
        cand_q <= cand_q + CNT_W'(1);
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.valid     = valid_q;
  assign bus.candidate = cand_q;

endmodule

// File: tb/tb_set_counter_multi.sv
// Randomised self-checking bench for set_counter_multi against a brute-force grid model.
module tb_set_counter_multi;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  set_counter_multi_if #(.COORD_W(4), .N_CIRC(3), .CNT_W(8), .K_W(2)) bus ();
  set_counter_multi #(.GRID(8), .COORD_W(4), .N_CIRC(3), .CNT_W(8), .K_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  set_counter_multi_if #(.COORD_W(5), .N_CIRC(4), .CNT_W(9), .K_W(3)) bus16 ();
  set_counter_multi #(.GRID(16), .COORD_W(5), .N_CIRC(4), .CNT_W(9), .K_W(3)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16)
  );

  // Current job description shared by the stimulus tasks and the model.
  int         jcx[4], jcy[4], jr[4];
  logic [3:0] jmask;
  int         jmode, jk;
  int         e0;

  typedef struct {
    int         cx, cy, r;
    logic [2:0] m;
    int         md, kk, exp;
  } vec_t;

  // Brute force: visit every grid point and apply the set rule directly.
  function automatic int model(input int g, input int n);
    int cnt = 0;
    for (int x = 1; x <= g; x++) begin
      for (int y = 1; y <= g; y++) begin
        int h = 0;
        int act = 0;
        bit ok;
        for (int i = 0; i < n; i++) begin
          if (jmask[n-1-i]) begin
            act++;
            if ((x - jcx[i]) * (x - jcx[i]) + (y - jcy[i]) * (y - jcy[i]) <= jr[i] * jr[i]) h++;
          end
        end
        case (jmode)
          0:       ok = (act != 0) && (h == act);
          1:       ok = (h >= 1);
          2:       ok = (h == jk);
          default: ok = (h >= jk);
        endcase
        if (ok) cnt++;
      end
    end
    return cnt;
  endfunction

  task automatic rand_job();
    for (int i = 0; i < 4; i++) begin
      jcx[i] = $urandom_range(0, 15);
      jcy[i] = $urandom_range(0, 15);
      jr[i]  = $urandom_range(0, 15);
    end
    jmask = 4'($urandom_range(0, 7));
    jmode = $urandom_range(0, 3);
    jk    = $urandom_range(0, 3);
  endtask

  task automatic drive_job();
    bus.central = {4'(jcx[0]), 4'(jcy[0]), 4'(jcx[1]), 4'(jcy[1]), 4'(jcx[2]), 4'(jcy[2])};
    bus.radius  = {4'(jr[0]), 4'(jr[1]), 4'(jr[2])};
    bus.mask    = jmask[2:0];
    bus.mode    = 2'(jmode);
    bus.k       = 2'(jk);
  endtask

  task automatic scramble();
    bus.central = 24'($urandom);
    bus.radius  = 12'($urandom);
    bus.mask    = 3'($urandom);
    bus.mode    = 2'($urandom);
    bus.k       = 2'($urandom);
  endtask

  // Present the job with en for one edge (E0); leaves time at E0+#1.
  task automatic launch();
    drive_job();
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    e0 = cyc;
    scramble();
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    bus16.en = 1'b0;
    bus16.central = '0;
    bus16.radius = '0;
    bus16.mask = '0;
    bus16.mode = '0;
    bus16.k = '0;
    scramble();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.candidate !== 8'd0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b cand=%0d, required 0/0/0",
               bus.busy, bus.valid, bus.candidate);
    end
    checks++;
    if (bus16.busy !== 1'b0 || bus16.valid !== 1'b0 || bus16.candidate !== 9'd0) begin
      errors++;
      $display("FAIL reset16: busy=%b valid=%b cand=%0d, required 0/0/0",
               bus16.busy, bus16.valid, bus16.candidate);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_spec_vectors();
    vec_t vt[11];
    int   lat;
    vt = '{'{4, 4, 2, 3'b100, 0, 0, 13}, '{1, 1, 0, 3'b100, 1, 0, 1},
           '{8, 8, 15, 3'b100, 1, 0, 64}, '{0, 0, 1, 3'b100, 1, 0, 0},
           '{4, 4, 2, 3'b111, 2, 2, 0},  '{4, 4, 2, 3'b111, 3, 2, 13},
           '{4, 4, 2, 3'b111, 2, 0, 51}, '{4, 4, 2, 3'b111, 0, 0, 13},
           '{4, 4, 2, 3'b000, 0, 0, 0},  '{4, 4, 2, 3'b000, 1, 0, 0},
           '{4, 4, 2, 3'b000, 3, 0, 64}};
    foreach (vt[v]) begin
      for (int i = 0; i < 3; i++) begin
        jcx[i] = vt[v].cx;
        jcy[i] = vt[v].cy;
        jr[i]  = vt[v].r;
      end
      jmask = {1'b0, vt[v].m};
      jmode = vt[v].md;
      jk    = vt[v].kk;
      launch();
      wait_valid(lat);
      checks++;
      if (lat !== 67 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d latency: lat=%0d busy=%b, required 67/0", v, lat, bus.busy);
      end
      checks++;
      if (int'(bus.candidate) !== vt[v].exp) begin
        errors++;
        $display("FAIL vec%0d candidate: got %0d, required %0d", v, bus.candidate, vt[v].exp);
      end
      @(posedge clk);
      #1;
      if (v == 0) begin
        checks++;
        if (bus.valid !== 1'b0 || int'(bus.candidate) !== vt[v].exp) begin
          errors++;
          $display("FAIL hold: valid=%b cand=%0d, required 0/%0d", bus.valid, bus.candidate,
                   vt[v].exp);
        end
      end
    end
  endtask

  task automatic test_random();
    int lat, exp;
    for (int t = 0; t < 10; t++) begin
      rand_job();
      exp = model(8, 3);
      launch();
      wait_valid(lat);
      checks++;
      if (lat !== 67 || int'(bus.candidate) !== exp) begin
        errors++;
        $display("FAIL random%0d: lat=%0d cand=%0d, required 67/%0d (mask=%b mode=%0d k=%0d)",
                 t, lat, bus.candidate, exp, jmask[2:0], jmode, jk);
      end
    end
  endtask

  task automatic test_en_while_busy();
    int lat, exp;
    rand_job();
    jmode = 3;
    jk    = 1;
    exp   = model(8, 3);
    launch();
    repeat (9) @(posedge clk);
    #1;
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    bus.en = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_en: busy=%b, required 1", bus.busy);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 67 || int'(bus.candidate) !== exp) begin
      errors++;
      $display("FAIL busy_en result: lat=%0d cand=%0d, required 67/%0d", lat, bus.candidate, exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat, exp_a, exp_b, va;
    rand_job();
    exp_a = model(8, 3);
    launch();
    wait_valid(lat);
    checks++;
    if (lat !== 67 || int'(bus.candidate) !== exp_a) begin
      errors++;
      $display("FAIL b2b first: lat=%0d cand=%0d, required 67/%0d", lat, bus.candidate, exp_a);
    end
    va = cyc;
    rand_job();
    jmode = 1;
    exp_b = model(8, 3);
    launch();
    checks++;
    if (e0 - va !== 1 || bus.busy !== 1'b1 || bus.candidate !== 8'd0) begin
      errors++;
      $display("FAIL b2b accept: gap=%0d busy=%b cand=%0d, required 1/1/0",
               e0 - va, bus.busy, bus.candidate);
    end
    wait_valid(lat);
    checks++;
    if (lat + 1 !== 68 || int'(bus.candidate) !== exp_b) begin
      errors++;
      $display("FAIL b2b second: valid gap=%0d cand=%0d, required 68/%0d",
               lat + 1, bus.candidate, exp_b);
    end
  endtask

  task automatic test_reset_mid_job();
    int lat, exp, seen;
    rand_job();
    jmode = 3;
    jk    = 0;
    launch();
    repeat (29) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.candidate !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset: busy=%b valid=%b cand=%0d, required 0/0/0",
               bus.busy, bus.valid, bus.candidate);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (bus.valid === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset pulse: valid pulses=%0d, required 0", seen);
    end
    rand_job();
    exp = model(8, 3);
    launch();
    wait_valid(lat);
    checks++;
    if (lat !== 67 || int'(bus.candidate) !== exp) begin
      errors++;
      $display("FAIL post_reset job: lat=%0d cand=%0d, required 67/%0d", lat, bus.candidate, exp);
    end
  endtask

  task automatic test_grid16();
    int lat, exp;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin
        for (int i = 0; i < 4; i++) begin
          jcx[i] = 0;
          jcy[i] = 0;
          jr[i]  = 0;
        end
        jcx[0] = 8;
        jcy[0] = 8;
        jr[0]  = 31;
        jmask  = 4'b1000;
        jmode  = 1;
        jk     = 0;
        exp    = 256;
      end else begin
        for (int i = 0; i < 4; i++) begin
          jcx[i] = $urandom_range(0, 31);
          jcy[i] = $urandom_range(0, 31);
          jr[i]  = $urandom_range(0, 31);
        end
        jmask = 4'($urandom_range(1, 15));
        jmode = $urandom_range(0, 3);
        jk    = $urandom_range(0, 4);
        exp   = model(16, 4);
      end
      bus16.central = {5'(jcx[0]), 5'(jcy[0]), 5'(jcx[1]), 5'(jcy[1]),
                       5'(jcx[2]), 5'(jcy[2]), 5'(jcx[3]), 5'(jcy[3])};
      bus16.radius  = {5'(jr[0]), 5'(jr[1]), 5'(jr[2]), 5'(jr[3])};
      bus16.mask    = jmask;
      bus16.mode    = 2'(jmode);
      bus16.k       = 3'(jk);
      bus16.en      = 1'b1;
      @(posedge clk);
      #1;
      bus16.en = 1'b0;
      e0 = cyc;
      lat = -1;
      for (int n = 0; n < 400; n++) begin
        @(posedge clk);
        #1;
        if (bus16.valid === 1'b1) begin
          lat = cyc - e0;
          break;
        end
      end
      checks++;
      if (lat !== 259 || int'(bus16.candidate) !== exp) begin
        errors++;
        $display("FAIL grid16_%0d: lat=%0d cand=%0d, required 259/%0d",
                 t, lat, bus16.candidate, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_random();
    test_en_while_busy();
    test_back_to_back();
    test_reset_mid_job();
    test_grid16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
